rot_l_seq: RTL and testbench



---
 rtl/rot_l_seq.sv | 98 +++++++++
 tb/tb_rot_l_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_l_seq.sv
// Sequential left-rotator: accepts a word and amount on start, rotates one
// bit per clock, and holds the result on dout until the next completion.
module rot_l_seq #(
   parameter int WIDTH = 6,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   input  logic [AW-1:0]    amt,
   output logic [WIDTH-1:0] dout,
   output logic             busy,
   output logic             done
);

   localparam logic [AW:0]   WIDTH_E = (AW+1)'(WIDTH);
   localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);
   localparam logic [AW-1:0] CNT_ONE = AW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROT  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state, state_nx;
   logic [WIDTH-1:0]  sr;
   logic [AW-1:0]     cnt;
   logic [AW-1:0]     k_smp;

   // Amounts in [WIDTH, 2^AW) fold back by one word width.
   function automatic logic [AW-1:0] reduce_amt(input logic [AW-1:0] a);
      if ({1'b0, a} < WIDTH_E)
         return a;
      else
         return a - WIDTH_A;
   endfunction

   function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], v[WIDTH-1]};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      k_smp    = reduce_amt(amt);
      case (state)
         IDLE: begin
            if (start)
               state_nx = (k_smp == '0) ? DONE : ROT;
         end
         ROT: begin
            if (cnt == CNT_ONE)
               state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: load on accept, rotate in ROT, capture result on DONE entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr   <= '0;
         cnt  <= '0;
         dout <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sr  <= din;
                  cnt <= k_smp;
                  if (k_smp == '0)
                     dout <= din;
               end
            end
            ROT: begin
               sr  <= rotl1(sr);
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE)
                  dout <= rotl1(sr);
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == ROT);
   assign done = (state == DONE);

endmodule

// File: tb/tb_rot_l_seq.sv
// Self-checking bench for rot_l_seq: directed scenarios, an exhaustive sweep
// and random traffic compared against an arithmetic rotate model.
module tb_rot_l_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [5:0] din;
   logic [2:0] amt;
   logic [5:0] dout;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   rot_l_seq #(.WIDTH(6), .AW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .din   (din),
      .amt   (amt),
      .dout  (dout),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Left rotate of a 6-bit word is multiplication by 2^k modulo 63 (all-ones is fixed).
   function automatic logic [5:0] ref_rotl(input logic [5:0] v, input int a);
      int k;
      int x;
      k = a % 6;
      x = int'(v);
      if (x == 63)
         return 6'd63;
      return 6'((x * (1 << k)) % 63);
   endfunction

   // Issues one request from IDLE and observes it until one cycle past done.
   task automatic run_req(input logic [5:0] d, input logic [2:0] a,
                          output int done_edge, output int busy_cnt,
                          output int done_cnt, output int overlap,
                          output logic [5:0] res);
      done_edge = -1;
      busy_cnt  = 0;
      done_cnt  = 0;
      overlap   = 0;
      res       = dout;
      start = 1'b1;
      din   = d;
      amt   = a;
      @(posedge clk); #1;
      start = 1'b0;
      din   = 6'($urandom);
      amt   = 3'($urandom);
      for (int e = 0; e < 20; e++) begin
         if (busy && done) overlap++;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_edge = e;
            res = dout;
            break;
         end
         @(posedge clk); #1;
      end
      if (done_edge >= 0) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
         if (busy) overlap++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         start = 1'($urandom);
         din   = 6'($urandom);
         amt   = 3'($urandom);
         @(posedge clk); #1;
         checks++;
         if (dout !== 6'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: dout=%b busy=%b done=%b required dout=000000 busy=0 done=0",
                     dout, busy, done);
         end
      end
      start = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (dout !== 6'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: dout=%b busy=%b done=%b required dout=000000 busy=0 done=0",
                     dout, busy, done);
         end
      end
   endtask

   task automatic test_basic;
      int de, bc, dc, ov;
      logic [5:0] r;
      run_req(6'b110100, 3'd2, de, bc, dc, ov, r);
      checks++;
      if (r !== 6'b010011 || de !== 2 || bc !== 2 || dc !== 1 || ov !== 0) begin
         errors++;
         $display("FAIL basic: dout=%b done_edge=%0d busy=%0d pulses=%0d overlap=%0d required 010011/2/2/1/0",
                  r, de, bc, dc, ov);
      end
   endtask

   task automatic test_zero_and_wrap;
      int de, bc, dc, ov;
      logic [5:0] r;
      run_req(6'b101011, 3'd0, de, bc, dc, ov, r);
      checks++;
      if (r !== 6'b101011 || de !== 0 || bc !== 0 || dc !== 1 || ov !== 0) begin
         errors++;
         $display("FAIL amt_zero: dout=%b done_edge=%0d busy=%0d pulses=%0d required 101011/0/0/1",
                  r, de, bc, dc);
      end
      run_req(6'b100001, 3'd7, de, bc, dc, ov, r);
      checks++;
      if (r !== 6'b000011 || de !== 1 || bc !== 1 || dc !== 1 || ov !== 0) begin
         errors++;
         $display("FAIL amt_seven: dout=%b done_edge=%0d busy=%0d pulses=%0d required 000011/1/1/1",
                  r, de, bc, dc);
      end
      run_req(6'b011001, 3'd6, de, bc, dc, ov, r);
      checks++;
      if (r !== 6'b011001 || de !== 0 || bc !== 0 || dc !== 1) begin
         errors++;
         $display("FAIL amt_six: dout=%b done_edge=%0d busy=%0d pulses=%0d required 011001/0/0/1",
                  r, de, bc, dc);
      end
   endtask

   task automatic test_start_while_busy;
      int de, bc, dc, ov;
      int edge_no;
      logic [5:0] r;
      logic [5:0] prev;
      prev    = dout;
      edge_no = -1;
      start = 1'b1;
      din   = 6'b000001;
      amt   = 3'd5;
      @(posedge clk); #1;
      din = 6'b111111;
      amt = 3'd1;
      for (int e = 0; e < 20; e++) begin
         if (done) begin
            edge_no = e;
            break;
         end
         checks++;
         if (dout !== prev) begin
            errors++;
            $display("FAIL hold_during_rot: dout=%b required %b", dout, prev);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (dout !== 6'b100000 || edge_no !== 5) begin
         errors++;
         $display("FAIL start_ignored: dout=%b done_edge=%0d required 100000/5", dout, edge_no);
      end
      start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL no_queue: busy=%b done=%b required 0/0", busy, done);
      end
      run_req(6'b110010, 3'd3, de, bc, dc, ov, r);
      checks++;
      if (r !== ref_rotl(6'b110010, 3) || de !== 3 || dc !== 1) begin
         errors++;
         $display("FAIL after_busy: dout=%b done_edge=%0d pulses=%0d required %b/3/1",
                  r, de, dc, ref_rotl(6'b110010, 3));
      end
   endtask

   task automatic test_reset_mid_op;
      int de, bc, dc, ov;
      int pulses;
      logic [5:0] d;
      logic [2:0] a;
      logic [5:0] r;
      start = 1'b1;
      din   = 6'b011011;
      amt   = 3'd4;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || dout !== 6'b0) begin
         errors++;
         $display("FAIL async_abort: dout=%b busy=%b done=%b required 000000/0/0", dout, busy, done);
      end
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done || busy) pulses++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (done || busy) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL abort_quiet: active_cycles=%0d required 0", pulses);
      end
      d = 6'($urandom);
      a = 3'($urandom_range(1, 5));
      run_req(d, a, de, bc, dc, ov, r);
      checks++;
      if (r !== ref_rotl(d, int'(a)) || de !== int'(a) || dc !== 1) begin
         errors++;
         $display("FAIL after_reset: dout=%b done_edge=%0d pulses=%0d required %b/%0d/1",
                  r, de, dc, ref_rotl(d, int'(a)), a);
      end
   endtask

   task automatic test_back_to_back;
      int de, bc, dc, ov;
      int k;
      logic [5:0] r;
      for (int d = 0; d < 64; d++) begin
         for (int a = 0; a < 8; a++) begin
            k = a % 6;
            run_req(6'(d), 3'(a), de, bc, dc, ov, r);
            checks++;
            if (r !== ref_rotl(6'(d), a) || de !== k || bc !== k || dc !== 1 || ov !== 0) begin
               errors++;
               $display("FAIL sweep d=%0d a=%0d: dout=%b edge=%0d busy=%0d pulses=%0d overlap=%0d required %b/%0d/%0d/1/0",
                        d, a, r, de, bc, dc, ov, ref_rotl(6'(d), a), k, k);
            end
         end
      end
   endtask

   task automatic test_random;
      int de, bc, dc, ov;
      logic [5:0] d;
      logic [2:0] a;
      logic [5:0] r;
      for (int n = 0; n < 150; n++) begin
         d = 6'($urandom);
         a = 3'($urandom);
         run_req(d, a, de, bc, dc, ov, r);
         checks++;
         if (r !== ref_rotl(d, int'(a)) || $countones(r) != $countones(d) ||
             de !== int'(a) % 6 || dc !== 1) begin
            errors++;
            $display("FAIL random d=%b a=%0d: dout=%b edge=%0d pulses=%0d required %b/%0d/1",
                     d, a, r, de, dc, ref_rotl(d, int'(a)), int'(a) % 6);
         end
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      din   = '0;
      amt   = '0;
      #2;
      test_reset;
      test_basic;
      test_zero_and_wrap;
      test_start_while_busy;
      test_reset_mid_op;
      test_back_to_back;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
